// File: rtl/mul_share_pkg.sv
// Shared definitions for the two-master GF(2^N) multiplier arbiter.
// State encoding and counter-width helper.
package mul_share_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE
  } state_e;

  // ceil(log2(v)), never below one bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker.
// On a tie the requester that was not served last wins.
module rr_pick2
  import mul_share_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       idx_o
);

  assign valid_o = |req_i;

  // Pick the single requester, or alternate on a tie
  always_comb begin
    idx_o = 1'b0;
    unique case (1'b1)
      (&req_i):          idx_o = ~last_i;
      (req_i == 2'b10):  idx_o = 1'b1;
      default:           idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fault-reporting GF(2^N) multiplier between two requesters,
// with bounded retry on reported faults and a no-answer watchdog.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N         = 233,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [N-1:0] A0,
  input  logic [N-1:0] B0,
  input  logic [N-1:0] A1,
  input  logic [N-1:0] B1,
  output logic         DONE0,
  output logic         DONE1,
  output logic         FAIL,
  output logic [N-1:0] DOUT,
  output logic         BUSY,
  output logic         GRANT,
  output logic [N-1:0] MUL_A,
  output logic [N-1:0] MUL_B,
  output logic         MUL_IN_VALID,
  input  logic         MUL_OUT_VALID,
  input  logic         MUL_ERROR,
  input  logic [N-1:0] MUL_DOUT
);

  localparam int RW = clog2(MAX_RETRY + 1);
  localparam int WW = clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  state_e          state_q;
  logic            grant_q;
  logic            last_q;
  logic [RW-1:0]   retry_q;
  logic [WW-1:0]   wd_q;
  logic [N-1:0]    mula_q;
  logic [N-1:0]    mulb_q;
  logic            miv_q;
  logic            done0_q;
  logic            done1_q;
  logic            fail_q;
  logic [N-1:0]    dout_q;
  logic            pick_v;
  logic            pick_idx;

  rr_pick2 u_pick (
    .req_i   ({REQ1, REQ0}),
    .last_i  (last_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  // Arbitration FSM with registered handshake and completion outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      retry_q <= '0;
      wd_q    <= '0;
      mula_q  <= '0;
      mulb_q  <= '0;
      miv_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      fail_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      miv_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_v) begin
            grant_q <= pick_idx;
            mula_q  <= pick_idx ? A1 : A0;
            mulb_q  <= pick_idx ? B1 : B0;
            retry_q <= '0;
            wd_q    <= '0;
            miv_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (MUL_OUT_VALID) begin
            if (MUL_ERROR && (retry_q < RMAX)) begin
              retry_q <= retry_q + RW'(1);
              miv_q   <= 1'b1;
              state_q <= ISSUE;
            end else begin
              dout_q  <= MUL_DOUT;
              fail_q  <= MUL_ERROR;
              done0_q <= ~grant_q;
              done1_q <= grant_q;
              state_q <= DONE;
            end
          end else if (wd_q == WMAX) begin
            fail_q  <= 1'b1;
            done0_q <= ~grant_q;
            done1_q <= grant_q;
            state_q <= DONE;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        DONE: begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign GRANT        = grant_q;
  assign MUL_A        = mula_q;
  assign MUL_B        = mulb_q;
  assign MUL_IN_VALID = miv_q;
  assign DONE0        = done0_q;
  assign DONE1        = done1_q;
  assign FAIL         = fail_q;
  assign DOUT         = dout_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a
// behavioural GF(2^233) multiplier that can fault or stay silent.
module tb_mul_share_arbiter;

  localparam int N       = 233;
  localparam int TIMEOUT = 1023;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         REQ0 = 1'b0, REQ1 = 1'b0;
  logic [N-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         DONE0, DONE1, FAIL, BUSY, GRANT, MUL_IN_VALID;
  logic [N-1:0] DOUT, MUL_A, MUL_B;
  logic         MUL_OUT_VALID = 1'b0, MUL_ERROR = 1'b0;
  logic [N-1:0] MUL_DOUT = '0;

  mul_share_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .DONE0(DONE0), .DONE1(DONE1), .FAIL(FAIL), .DOUT(DOUT),
    .BUSY(BUSY), .GRANT(GRANT),
    .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_IN_VALID(MUL_IN_VALID),
    .MUL_OUT_VALID(MUL_OUT_VALID), .MUL_ERROR(MUL_ERROR),
    .MUL_DOUT(MUL_DOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic         idx;
    logic         fail;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // multiplier model controls
  int lat = 3;
  int err_left = 0;
  bit err_all = 0;
  bit mute = 0;
  int issues = 0;
  int last_issue_cyc = 0;

  function automatic void chk(string nm, logic [N-1:0] act, logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  function automatic logic [N-1:0] gf_mul(logic [N-1:0] a, logic [N-1:0] b);
    logic [N-1:0] r, p;
    p = '0;
    p[74] = 1'b1;
    p[0] = 1'b1;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r[N-1] ? ({r[N-2:0], 1'b0} ^ p) : {r[N-2:0], 1'b0};
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic exp_t mk(logic i, logic f, logic [N-1:0] a,
                              logic [N-1:0] b, logic [N-1:0] d);
    exp_t e;
    e.idx = i; e.fail = f; e.a = a; e.b = b; e.dout = d;
    return e;
  endfunction

  // behavioural multiplier: answers lat cycles after each start pulse
  initial begin
    logic [N-1:0] ca, cb;
    forever begin
      @(negedge CLK);
      while (MUL_IN_VALID) begin
        issues++;
        last_issue_cyc = cyc;
        ca = MUL_A;
        cb = MUL_B;
        if (mute) break;
        repeat (lat) @(negedge CLK);
        MUL_OUT_VALID = 1'b1;
        MUL_ERROR = err_all || (err_left > 0);
        if (err_left > 0) err_left--;
        MUL_DOUT = gf_mul(ca, cb);
        @(negedge CLK);
        MUL_OUT_VALID = 1'b0;
        MUL_ERROR = 1'b0;
      end
    end
  end

  // monitor: operand bus on each start, result on each DONE
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MUL_IN_VALID && exp_q.size() > 0) begin
        chk("mul_a", MUL_A, exp_q[0].a);
        chk("mul_b", MUL_B, exp_q[0].b);
      end
      if (DONE0 || DONE1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got DONE0=%0b DONE1=%0b expected none",
                   DONE0, DONE1);
        end else begin
          e = exp_q.pop_front();
          chk("done_both", N'(DONE0 & DONE1), '0);
          chk("done_idx", N'(DONE1), N'(e.idx));
          chk("grant", N'(GRANT), N'(e.idx));
          chk("fail", N'(FAIL), N'(e.fail));
          chk("dout", DOUT, e.dout);
        end
      end
    end
  end

  task automatic wait_done(input bit idx, input int budget, output int dcyc);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge CLK);
      if (idx ? DONE1 : DONE0) got = 1;
    end
    dcyc = cyc;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout%0d: got no DONE expected one within %0d",
               idx, budget);
    end
  endtask

  task automatic wait_issue(output int icyc);
    bit got;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (MUL_IN_VALID) got = 1;
    end
    icyc = cyc;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got no MUL_IN_VALID expected one");
    end
  endtask

  task automatic requester(input bit idx, input int n);
    int d;
    for (int k = 0; k < n; k++) begin
      if (idx) REQ1 = 1'b1; else REQ0 = 1'b1;
      wait_done(idx, 200, d);
      if (idx) REQ1 = 1'b0; else REQ0 = 1'b0;
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [N-1:0] x;
    int c, ic, d;
    x = N'({8{32'hA5C30F96}});

    // reset state
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", N'(BUSY), '0);
    chk("rst_grant", N'(GRANT), '0);
    chk("rst_done", N'({DONE1, DONE0}), '0);
    chk("rst_miv", N'(MUL_IN_VALID), '0);
    chk("rst_fail", N'(FAIL), '0);
    chk("rst_dout", DOUT, '0);
    chk("rst_mula", MUL_A, '0);

    // tie from reset: expect 0,1,0,1
    lat = 3;
    A0 = N'(2); B0 = N'(3);
    A1 = N'(4); B1 = N'(5);
    exp_q.push_back(mk(1'b0, 1'b0, N'(2), N'(3), N'(6)));
    exp_q.push_back(mk(1'b1, 1'b0, N'(4), N'(5), N'('h14)));
    exp_q.push_back(mk(1'b0, 1'b0, N'(2), N'(3), N'(6)));
    exp_q.push_back(mk(1'b1, 1'b0, N'(4), N'(5), N'('h14)));
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    RST_N = 1'b1;
    fork
      requester(1'b0, 2);
      requester(1'b1, 2);
    join
    repeat (2) @(negedge CLK);

    // single multiply, L=233, 1*x = x
    lat = 233;
    A0 = N'(1); B0 = x;
    exp_q.push_back(mk(1'b0, 1'b0, N'(1), x, x));
    REQ0 = 1'b1;
    c = cyc;
    wait_issue(ic);
    wait_done(1'b0, 300, d);
    REQ0 = 1'b0;
    chk("issue_lat", N'(ic - c), N'(1));
    chk("done_lat", N'(d - c), N'(235));
    repeat (2) @(negedge CLK);
    chk("idle_busy", N'(BUSY), '0);

    // two faults then clean: 3 issues
    lat = 4;
    issues = 0;
    err_left = 2;
    A1 = N'(2); B1 = N'(3);
    exp_q.push_back(mk(1'b1, 1'b0, N'(2), N'(3), N'(6)));
    REQ1 = 1'b1;
    wait_done(1'b1, 200, d);
    REQ1 = 1'b0;
    chk("recov_issues", N'(issues), N'(3));
    repeat (2) @(negedge CLK);

    // every strobe faulty: 4 issues then FAIL
    lat = 2;
    issues = 0;
    err_all = 1;
    A0 = N'(4); B0 = N'(5);
    exp_q.push_back(mk(1'b0, 1'b1, N'(4), N'(5), N'('h14)));
    REQ0 = 1'b1;
    wait_done(1'b0, 200, d);
    REQ0 = 1'b0;
    err_all = 0;
    chk("exh_issues", N'(issues), N'(4));
    repeat (2) @(negedge CLK);

    // silent multiplier: watchdog, DOUT held
    mute = 1;
    A1 = N'(6); B1 = N'(7);
    exp_q.push_back(mk(1'b1, 1'b1, N'(6), N'(7), N'('h14)));
    REQ1 = 1'b1;
    wait_done(1'b1, 1100, d);
    REQ1 = 1'b0;
    mute = 0;
    chk("wd_lat", N'(d - last_issue_cyc), N'(TIMEOUT + 2));
    repeat (2) @(negedge CLK);

    // reset while waiting; late strobe must be ignored
    lat = 20;
    A0 = N'(8); B0 = N'(9);
    REQ0 = 1'b1;
    wait_issue(ic);
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("mrst_busy", N'(BUSY), '0);
    chk("mrst_dout", DOUT, '0);
    chk("mrst_fail", N'(FAIL), '0);
    chk("mrst_mula", MUL_A, '0);
    RST_N = 1'b1;
    repeat (25) @(negedge CLK);
    chk("late_busy", N'(BUSY), '0);
    chk("late_dout", DOUT, '0);

    // next request after the abort
    lat = 3;
    A1 = N'(3); B1 = N'(3);
    exp_q.push_back(mk(1'b1, 1'b0, N'(3), N'(3), N'(5)));
    REQ1 = 1'b1;
    wait_done(1'b1, 100, d);
    REQ1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sb_empty", N'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "global timeout");
  end

endmodule
